// File: rtl/aes_pkg.sv
// Shared AES types and the FIPS-197 forward S-box table.
package aes_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sched_state_t;
    typedef enum logic {SB, KW} client_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/sbox_lut.sv
// One combinational AES S-box lookup lane.
module sbox_lut
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = SBOX[din];

endmodule

// File: rtl/sbox_scheduler.sv
// Shares LANES S-box lookups between the SubBytes and key-word clients,
// one operation in flight, results substituted in place in a 128-bit buffer.
//
//   state | meaning
//   IDLE  | arbitrate and accept one request into the buffer
//   RUN   | substitute LANES bytes per cycle, cnt selects the beat
//   DONE  | hold owner's response until its rsp_ready
module sbox_scheduler
    import aes_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sb_req_valid,
    output logic         sb_req_ready,
    input  logic [127:0] sb_req_data,
    output logic         sb_rsp_valid,
    input  logic         sb_rsp_ready,
    output logic [127:0] sb_rsp_data,
    input  logic         kw_req_valid,
    output logic         kw_req_ready,
    input  logic [31:0]  kw_req_data,
    output logic         kw_rsp_valid,
    input  logic         kw_rsp_ready,
    output logic [31:0]  kw_rsp_data,
    output logic         busy
);

    sched_state_t state_q, state_d;
    client_t      owner_q, owner_d;
    client_t      last_q, last_d;
    logic [127:0] buf_q, buf_d, buf_sub;
    logic [3:0]   cnt_q, cnt_d;
    logic [3:0]   last_beat;
    logic         tie, sb_fire, kw_fire;

    logic [3:0] lane_idx [LANES];
    logic [7:0] lane_in  [LANES];
    logic [7:0] lane_out [LANES];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lane_idx[i] = 4'(cnt_q * LANES + i);
        assign lane_in[i]  = buf_q[{lane_idx[i], 3'b000} +: 8];
        sbox_lut u_lut (
            .din  (lane_in[i]),
            .dout (lane_out[i])
        );
    end

    always_comb begin
        buf_sub = buf_q;
        for (int i = 0; i < LANES; i++) begin
            buf_sub[{lane_idx[i], 3'b000} +: 8] = lane_out[i];
        end
    end

    assign last_beat = (owner_q == SB) ? 4'(16 / LANES - 1) : 4'(4 / LANES - 1);

    // On a tie the client granted last time is masked off.
    assign tie          = sb_req_valid && kw_req_valid;
    assign sb_req_ready = (state_q == IDLE) && !(tie && last_q == SB);
    assign kw_req_ready = (state_q == IDLE) && !(tie && last_q == KW);
    assign sb_fire      = sb_req_valid && sb_req_ready;
    assign kw_fire      = kw_req_valid && kw_req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= SB;
            last_q  <= KW;
            buf_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (sb_fire) begin
                    buf_d   = sb_req_data;
                    cnt_d   = '0;
                    owner_d = SB;
                    last_d  = SB;
                    state_d = RUN;
                end else if (kw_fire) begin
                    buf_d   = {96'b0, kw_req_data};
                    cnt_d   = '0;
                    owner_d = KW;
                    last_d  = KW;
                    state_d = RUN;
                end
            end
            RUN: begin
                buf_d = buf_sub;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if ((owner_q == SB && sb_rsp_ready) || (owner_q == KW && kw_rsp_ready)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sb_rsp_valid = (state_q == DONE) && (owner_q == SB);
    assign kw_rsp_valid = (state_q == DONE) && (owner_q == KW);
    assign sb_rsp_data  = sb_rsp_valid ? buf_q : '0;
    assign kw_rsp_data  = kw_rsp_valid ? buf_q[31:0] : '0;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_sbox_scheduler.sv
// Directed scoreboard bench for sbox_scheduler at LANES = 1.
module tb_sbox_scheduler;

    logic         clk = 1'b0;
    logic         reset;
    logic         sb_req_valid, sb_req_ready;
    logic [127:0] sb_req_data;
    logic         sb_rsp_valid, sb_rsp_ready;
    logic [127:0] sb_rsp_data;
    logic         kw_req_valid, kw_req_ready;
    logic [31:0]  kw_req_data;
    logic         kw_rsp_valid, kw_rsp_ready;
    logic [31:0]  kw_rsp_data;
    logic         busy;

    int n_pass  = 0;
    int n_total = 0;

    logic [127:0] sb_q [$];
    logic [31:0]  kw_q [$];
    int           grant_log [$];
    logic [127:0] sb_exp_next;
    logic [31:0]  kw_exp_next;

    localparam logic [127:0] SB_ZERO_EXP = {16{8'h63}};
    localparam logic [127:0] SB_SEQ      = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] SB_SEQ_EXP  = 128'h76abd7fe2b670130c56f6bf27b777c63;

    sbox_scheduler #(.LANES(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .sb_req_valid (sb_req_valid),
        .sb_req_ready (sb_req_ready),
        .sb_req_data  (sb_req_data),
        .sb_rsp_valid (sb_rsp_valid),
        .sb_rsp_ready (sb_rsp_ready),
        .sb_rsp_data  (sb_rsp_data),
        .kw_req_valid (kw_req_valid),
        .kw_req_ready (kw_req_ready),
        .kw_req_data  (kw_req_data),
        .kw_rsp_valid (kw_rsp_valid),
        .kw_rsp_ready (kw_rsp_ready),
        .kw_rsp_data  (kw_rsp_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Handshakes complete on the posedge following this negedge sample.
    always @(negedge clk) begin
        if (!reset) begin
            if (sb_req_valid && sb_req_ready) begin
                sb_q.push_back(sb_exp_next);
                grant_log.push_back(0);
            end
            if (kw_req_valid && kw_req_ready) begin
                kw_q.push_back(kw_exp_next);
                grant_log.push_back(1);
            end
            if (sb_rsp_valid && sb_rsp_ready) begin
                check("sb_rsp_pending", 128'(sb_q.size() != 0), 128'd1);
                if (sb_q.size() != 0) check("sb_rsp_data", sb_rsp_data, sb_q.pop_front());
            end
            if (kw_rsp_valid && kw_rsp_ready) begin
                check("kw_rsp_pending", 128'(kw_q.size() != 0), 128'd1);
                if (kw_q.size() != 0) check("kw_rsp_data", 128'(kw_rsp_data), 128'(kw_q.pop_front()));
            end
        end
    end

    task automatic send_sb(input logic [127:0] data, input logic [127:0] exp);
        sb_req_data  = data;
        sb_exp_next  = exp;
        sb_req_valid = 1'b1;
        @(negedge clk);
        check("sb_req_ready_idle", 128'(sb_req_ready), 128'd1);
        @(posedge clk);
        #1 sb_req_valid = 1'b0;
    endtask

    task automatic send_kw(input logic [31:0] data, input logic [31:0] exp);
        kw_req_data  = data;
        kw_exp_next  = exp;
        kw_req_valid = 1'b1;
        @(negedge clk);
        check("kw_req_ready_idle", 128'(kw_req_ready), 128'd1);
        @(posedge clk);
        #1 kw_req_valid = 1'b0;
    endtask

    // Cycles from the accepting edge until the response is first valid.
    task automatic wait_rsp(input bit is_kw, input int exp_lat, input string tag);
        int lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!(is_kw ? kw_rsp_valid : sb_rsp_valid) && lat < 100);
        check(tag, 128'(lat), 128'(exp_lat));
        if (is_kw) check("sb_rsp_idle_nonowner", {sb_rsp_valid, sb_rsp_data}, '0);
        else       check("kw_rsp_idle_nonowner", 128'({kw_rsp_valid, kw_rsp_data}), '0);
    endtask

    task automatic take_rsp(input bit is_kw);
        if (is_kw) kw_rsp_ready = 1'b1; else sb_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        kw_rsp_ready = 1'b0;
        sb_rsp_ready = 1'b0;
        check("busy_after_rsp", 128'(busy), 128'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        sb_q.delete();
        kw_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int cyc;
        int pulses;
        reset        = 1'b1;
        sb_req_valid = 1'b0;
        sb_req_data  = '0;
        sb_rsp_ready = 1'b0;
        kw_req_valid = 1'b0;
        kw_req_data  = '0;
        kw_rsp_ready = 1'b0;
        sb_exp_next  = '0;
        kw_exp_next  = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_sb_rsp_valid", 128'(sb_rsp_valid), 128'd0);
        check("rst_kw_rsp_valid", 128'(kw_rsp_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_sb_req_ready", 128'(sb_req_ready), 128'd1);
        check("rst_kw_req_ready", 128'(kw_req_ready), 128'd1);
        check("rst_rsp_data", {sb_rsp_data}, 128'(kw_rsp_data));

        send_kw(32'h00010253, 32'h637c77ed);
        wait_rsp(1'b1, 4, "kw_latency");
        take_rsp(1'b1);

        send_sb('0, SB_ZERO_EXP);
        wait_rsp(1'b0, 16, "sb_zero_latency");
        take_rsp(1'b0);

        send_sb(SB_SEQ, SB_SEQ_EXP);
        wait_rsp(1'b0, 16, "sb_seq_latency");
        take_rsp(1'b0);

        // Backpressure in DONE
        send_sb(SB_SEQ, SB_SEQ_EXP);
        wait_rsp(1'b0, 16, "sb_bp_latency");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_sb_rsp_data", sb_rsp_data, SB_SEQ_EXP);
            check("bp_sb_rsp_valid", 128'(sb_rsp_valid), 128'd1);
            check("bp_req_ready", 128'({sb_req_ready, kw_req_ready}), 128'd0);
            check("bp_busy", 128'(busy), 128'd1);
        end
        take_rsp(1'b0);

        // Tie after reset, then both held continuously
        pulse_reset();
        grant_log.delete();
        sb_req_data  = '0;
        sb_exp_next  = SB_ZERO_EXP;
        kw_req_data  = 32'hffffffff;
        kw_exp_next  = 32'h16161616;
        sb_rsp_ready = 1'b1;
        kw_rsp_ready = 1'b1;
        sb_req_valid = 1'b1;
        kw_req_valid = 1'b1;
        @(negedge clk);
        check("tie_sb_req_ready", 128'(sb_req_ready), 128'd1);
        check("tie_kw_req_ready", 128'(kw_req_ready), 128'd0);
        cyc = 0;
        while (grant_log.size() < 4 && cyc < 300) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        sb_req_valid = 1'b0;
        kw_req_valid = 1'b0;
        check("alt_grant_count", 128'(grant_log.size() >= 4), 128'd1);
        for (int i = 0; i < 4; i++) begin
            check("alt_grant_order", 128'(grant_log.size() > i ? grant_log[i] : -1), 128'(i % 2));
        end
        cyc = 0;
        while (busy && cyc < 100) begin
            @(posedge clk);
            #1 cyc++;
        end
        check("alt_drained", 128'({busy, sb_q.size() == 0, kw_q.size() == 0}), 128'b011);
        sb_rsp_ready = 1'b0;
        kw_rsp_ready = 1'b0;

        // Reset during beat 7 of an SB run
        send_sb(SB_SEQ, SB_SEQ_EXP);
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        sb_q.delete();
        #1;
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_sb_rsp_valid", 128'(sb_rsp_valid), 128'd0);
        check("abort_buf", dut.buf_q, '0);
        check("abort_req_ready", 128'({sb_req_ready, kw_req_ready}), 128'b11);
        @(posedge clk);
        #1 reset = 1'b0;
        sb_rsp_ready = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 if (sb_rsp_valid) pulses++;
        end
        check("abort_no_rsp", 128'(pulses), 128'd0);
        sb_rsp_ready = 1'b0;
        send_kw(32'hffffffff, 32'h16161616);
        wait_rsp(1'b1, 4, "kw_ff_latency");
        take_rsp(1'b1);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
